// File: rtl/aec_pkg.sv
// Shared definitions for the expression-result transmitter: ASCII codes,
// formatter FSM states, the buffered entry payload and character helpers.
package aec_pkg;

    localparam int unsigned RESULT_W  = 7;
    localparam int unsigned CHAR_W    = 8;
    localparam int unsigned MAX_CHARS = 4;

    localparam logic [CHAR_W-1:0] ASCII_0     = 8'h30;
    localparam logic [CHAR_W-1:0] ASCII_9     = 8'h39;
    localparam logic [CHAR_W-1:0] ASCII_A_LC  = 8'h61;
    localparam logic [CHAR_W-1:0] ASCII_E     = 8'h45;
    localparam logic [CHAR_W-1:0] ASCII_R     = 8'h52;
    localparam logic [CHAR_W-1:0] ASCII_LF    = 8'h0A;
    localparam logic [CHAR_W-1:0] ASCII_EQ    = 8'h3D;
    localparam logic [CHAR_W-1:0] ASCII_LPAR  = 8'h28;
    localparam logic [CHAR_W-1:0] ASCII_RPAR  = 8'h29;
    localparam logic [CHAR_W-1:0] ASCII_PLUS  = 8'h2B;
    localparam logic [CHAR_W-1:0] ASCII_MINUS = 8'h2D;
    localparam logic [CHAR_W-1:0] ASCII_STAR  = 8'h2A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } tx_state_t;

    // One buffered evaluation result
    typedef struct packed {
        logic                legal;
        logic [RESULT_W-1:0] result;
    } entry_t;

    // Lowercase hex digit for a nibble
    function automatic logic [CHAR_W-1:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + CHAR_W'(nib);
        end
        return ASCII_A_LC + CHAR_W'(nib - 4'd10);
    endfunction

    // Decimal digit (0..9) to ASCII
    function automatic logic [CHAR_W-1:0] dec_char(input logic [3:0] dig);
        return ASCII_0 + CHAR_W'(dig);
    endfunction

endpackage

// File: rtl/aec_result_fifo.sv
// Result buffer between the evaluator and the formatter: DEPTH entries
// (power of two), pop takes precedence so a full FIFO can accept a push
// in the same cycle it is popped.
module aec_result_fifo
    import aec_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  entry_t                   wr_data,
    output entry_t                   rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rd_data   = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Storage array; contents need no reset, validity comes from the count
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

endmodule

// File: rtl/aec_result_tx.sv
// Turns buffered expression results into short ASCII strings for a
// valid/ready character sink. Legal results print as two hex digits + LF;
// illegal ones print "ERR" + LF. Defining AEC_TX_DECIMAL_EN switches legal
// results to unsigned decimal without leading zeros.
module aec_result_tx
    import aec_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [RESULT_W-1:0]           in_result,
    input  logic                          in_legal,
    output logic [CHAR_W-1:0]             tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    tx_state_t                          r_state;
    entry_t                             r_entry;
    logic [MAX_CHARS-1:0][CHAR_W-1:0]   r_list;
    logic [1:0]                         r_last;
    logic [1:0]                         r_idx;

    entry_t                             w_entry_in;
    entry_t                             w_head;
    logic                               w_full;
    logic                               w_empty;
    logic                               w_pop;
    logic [MAX_CHARS-1:0][CHAR_W-1:0]   w_list;
    logic [1:0]                         w_last;

    assign w_entry_in = '{legal: in_legal, result: in_result};
    assign w_pop      = (r_state == ST_IDLE) && !w_empty;

    aec_result_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid),
        .pop     (w_pop),
        .wr_data (w_entry_in),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (fifo_count)
    );

`ifdef AEC_TX_DECIMAL_EN
    logic [RESULT_W-1:0] w_rem;
    logic [3:0]          w_hund;
    logic [3:0]          w_tens;
    logic [3:0]          w_ones;

    // Decimal digits of a 0..127 value; hundreds is at most 1
    always_comb begin
        w_hund = 4'd0;
        w_rem  = r_entry.result;
        if (r_entry.result >= RESULT_W'(100)) begin
            w_hund = 4'd1;
            w_rem  = r_entry.result - RESULT_W'(100);
        end
        w_tens = 4'(w_rem / RESULT_W'(10));
        w_ones = 4'(w_rem % RESULT_W'(10));
    end
`endif

    // Character list for the latched entry; element 0 is sent first
    always_comb begin
        w_list = '0;
        w_last = 2'd0;
        if (!r_entry.legal) begin
            w_list = {ASCII_LF, ASCII_R, ASCII_R, ASCII_E};
            w_last = 2'd3;
        end else begin
`ifdef AEC_TX_DECIMAL_EN
            if (w_hund != 4'd0) begin
                w_list = {ASCII_LF, dec_char(w_ones), dec_char(w_tens), dec_char(w_hund)};
                w_last = 2'd3;
            end else if (w_tens != 4'd0) begin
                w_list = {8'h00, ASCII_LF, dec_char(w_ones), dec_char(w_tens)};
                w_last = 2'd2;
            end else begin
                w_list = {8'h00, 8'h00, ASCII_LF, dec_char(w_ones)};
                w_last = 2'd1;
            end
`else
            w_list = {8'h00, ASCII_LF, hex_char(r_entry.result[3:0]),
                      hex_char({1'b0, r_entry.result[6:4]})};
            w_last = 2'd2;
`endif
        end
    end

    // Formatter FSM: pop in IDLE, build the string in LOAD, stream it in SEND
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_entry  <= '0;
            r_list   <= '0;
            r_last   <= 2'd0;
            r_idx    <= 2'd0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_entry <= w_head;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_list   <= w_list;
                    r_last   <= w_last;
                    r_idx    <= 2'd0;
                    tx_data  <= w_list[0];
                    tx_valid <= 1'b1;
                    r_state  <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_valid && tx_ready) begin
                        if (r_idx == r_last) begin
                            tx_valid <= 1'b0;
                            r_idx    <= 2'd0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_idx   <= r_idx + 2'd1;
                            tx_data <= r_list[r_idx + 2'd1];
                        end
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky drop flag: a push that found the FIFO full with no pop alongside
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (in_valid && w_full && !w_pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aec_result_tx.sv
// Directed bench for aec_result_tx: table of single-result strings plus
// hand-written sequences for FIFO full/overflow and mid-string reset.
`timescale 1ns/1ps
module tb_aec_result_tx;

    localparam int unsigned FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [6:0] in_result;
    logic       in_legal;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [2:0] fifo_count;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aec_result_tx #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_result  (in_result),
        .in_legal   (in_legal),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    typedef struct {
        logic            legal;
        logic [6:0]      result;
        logic [3:0][7:0] ex;
        int              len;
        bit              toggle;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Reference string built from formatted text, independent of the RTL
    function automatic void model(input logic lg, input logic [6:0] rs,
                                  output logic [3:0][7:0] ex, output int len);
        string s;
        ex = '0;
        if (!lg) begin
            ex[0] = 8'h45; ex[1] = 8'h52; ex[2] = 8'h52; ex[3] = 8'h0A;
            len = 4;
        end else begin
`ifdef AEC_TX_DECIMAL_EN
            s = $sformatf("%0d", rs);
`else
            s = $sformatf("%02h", {1'b0, rs});
`endif
            for (int i = 0; i < s.len(); i++) ex[i] = s[i];
            ex[s.len()] = 8'h0A;
            len = s.len() + 1;
        end
    endfunction

    // One pulse; called at a negedge, returns at the next negedge
    task automatic pulse(input logic lg, input logic [6:0] rs);
        in_valid  = 1'b1;
        in_legal  = lg;
        in_result = rs;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // Single result from an empty/idle DUT: latency, characters, stalls
    task automatic run_vec(input string nm, input logic lg, input logic [6:0] rs,
                           input logic [3:0][7:0] ex, input int len, input bit toggle);
        int k;
        int cyc;
        bit seen;
        k = 0; cyc = 0; seen = 0;
        tx_ready = 1'b1;
        pulse(lg, rs);
        chk({nm, "_cnt"}, 32'(fifo_count), 1);
        while (k < len && cyc < 40) begin
            if (toggle) tx_ready = (cyc % 2 == 0);
            if (tx_valid) begin
                if (!seen) begin
                    chk({nm, "_lat"}, cyc, 2);
                    seen = 1;
                end
                chk($sformatf("%s_c%0d", nm, k), 32'(tx_data), 32'(ex[k]));
                if (tx_ready) k++;
            end else if (seen) begin
                chk({nm, "_gap"}, 32'(tx_valid), 1);
            end
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_done"}, k, len);
        chk({nm, "_idle"}, 32'(tx_valid), 0);
        tx_ready = 1'b1;
    endtask

    // Drain one expected string with tx_ready held high
    task automatic collect(input string nm, input logic lg, input logic [6:0] rs);
        logic [3:0][7:0] ex;
        int len;
        int k;
        int cyc;
        model(lg, rs, ex, len);
        k = 0; cyc = 0;
        tx_ready = 1'b1;
        while (k < len && cyc < 30) begin
            if (tx_valid) begin
                chk($sformatf("%s_c%0d", nm, k), 32'(tx_data), 32'(ex[k]));
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_done"}, k, len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][7:0] ex;
        int len;
        int cyc;

        rst = 1'b1; in_valid = 1'b0; in_legal = 1'b0; in_result = 7'd0; tx_ready = 1'b0;
        #1;
        chk("rst_valid", 32'(tx_valid), 0);
        chk("rst_data",  32'(tx_data), 0);
        chk("rst_cnt",   32'(fifo_count), 0);
        chk("rst_ov",    32'(overflow), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

`ifdef AEC_TX_DECIMAL_EN
        vecs[0] = '{1'b1, 7'd127, {8'h0A, 8'h37, 8'h32, 8'h31}, 4, 1'b0};
        vecs[1] = '{1'b0, 7'h55,  {8'h0A, 8'h52, 8'h52, 8'h45}, 4, 1'b0};
        vecs[2] = '{1'b1, 7'd0,   {8'h00, 8'h00, 8'h0A, 8'h30}, 2, 1'b1};
        vecs[3] = '{1'b1, 7'd9,   {8'h00, 8'h00, 8'h0A, 8'h39}, 2, 1'b0};
        vecs[4] = '{1'b1, 7'd42,  {8'h00, 8'h0A, 8'h32, 8'h34}, 3, 1'b0};
        vecs[5] = '{1'b1, 7'd100, {8'h0A, 8'h30, 8'h30, 8'h31}, 4, 1'b1};
`else
        vecs[0] = '{1'b1, 7'h2A, {8'h00, 8'h0A, 8'h61, 8'h32}, 3, 1'b0};
        vecs[1] = '{1'b0, 7'h55, {8'h0A, 8'h52, 8'h52, 8'h45}, 4, 1'b0};
        vecs[2] = '{1'b1, 7'h7F, {8'h00, 8'h0A, 8'h66, 8'h37}, 3, 1'b1};
        vecs[3] = '{1'b1, 7'h00, {8'h00, 8'h0A, 8'h30, 8'h30}, 3, 1'b0};
        vecs[4] = '{1'b1, 7'h5C, {8'h00, 8'h0A, 8'h63, 8'h35}, 3, 1'b0};
        vecs[5] = '{1'b1, 7'h09, {8'h00, 8'h0A, 8'h39, 8'h30}, 3, 1'b1};
`endif
        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].legal, vecs[i].result,
                    vecs[i].ex, vecs[i].len, vecs[i].toggle);
        end

        // Fill: the first pulse goes straight into the stalled sender, four are buffered
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) pulse(1'b1, 7'h10 + 7'(i));
        chk("full_cnt", 32'(fifo_count), 4);
        chk("full_ov",  32'(overflow), 0);
        collect("s10", 1'b1, 7'h10);
        chk("pre_cnt", 32'(fifo_count), 4);
        // Push lands on the same edge as the IDLE pop of a full FIFO
        pulse(1'b1, 7'h16);
        chk("simul_cnt", 32'(fifo_count), 4);
        chk("simul_ov",  32'(overflow), 0);
        collect("s11", 1'b1, 7'h11);
        collect("s12", 1'b1, 7'h12);
        collect("s13", 1'b1, 7'h13);
        collect("s14", 1'b1, 7'h14);
        collect("s16", 1'b1, 7'h16);
        chk("drain_cnt", 32'(fifo_count), 0);

        // Overflow: sixth pulse finds four buffered and the sender stalled
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) pulse(i != 2, 7'h20 + 7'(i));
        chk("ov_pre", 32'(overflow), 0);
        pulse(1'b1, 7'h25);
        chk("ov_cnt", 32'(fifo_count), 4);
        chk("ov_set", 32'(overflow), 1);
        for (int i = 0; i < 5; i++) collect($sformatf("o%0d", i), i != 2, 7'h20 + 7'(i));
        repeat (4) @(negedge clk);
        chk("ov_no_extra", 32'(tx_valid), 0);
        chk("ov_empty",    32'(fifo_count), 0);
        chk("ov_sticky",   32'(overflow), 1);

        // Reset after the first character of a string with another result queued
        pulse(1'b1, 7'h3B);
        pulse(1'b1, 7'h44);
        cyc = 0;
        while (!tx_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_started", 32'(tx_valid), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(tx_valid), 0);
        chk("mid_rst_cnt",   32'(fifo_count), 0);
        chk("mid_rst_data",  32'(tx_data), 0);
        chk("mid_rst_ov",    32'(overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_quiet%0d", i), 32'(tx_valid), 0);
        end
        model(1'b1, 7'h3B, ex, len);
        run_vec("post_rst", 1'b1, 7'h3B, ex, len, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
